// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use bubbles,
// post-branch flush sequencing, memory-busy freeze and saturating perf counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_ir,
    input  logic             id_valid,
    input  logic [31:0]      ex_ir,
    input  logic             ex_valid,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             stall_fe,
    output logic             bubble_ex,
    output logic             stall_ex,
    output logic             flush,
    output logic             flushing,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [6:0] OP_REG_ALU = 7'b0110011;
    localparam logic [6:0] OP_IMM_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   fcnt;
    logic [FW-1:0]   fcnt_nxt;
    logic            start;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic [6:0] id_op;
    logic [6:0] ex_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;
    logic       taken;
    logic       hazard;

    always_comb begin
        id_op    = id_ir[6:0];
        ex_op    = ex_ir[6:0];
        rd       = ex_ir[11:7];
        rs1      = id_ir[19:15];
        rs2      = id_ir[24:20];
        uses_rs1 = id_op inside {OP_REG_ALU, OP_IMM_ALU, OP_LOAD,
                                 OP_STORE, OP_BRANCH, OP_JALR};
        uses_rs2 = id_op inside {OP_REG_ALU, OP_STORE, OP_BRANCH};
        load_use = ex_valid && id_valid && (ex_op == OP_LOAD) &&
                   (rd != 5'd0) &&
                   ((uses_rs1 && rs1 == rd) || (uses_rs2 && rs2 == rd));
        taken    = ex_valid && branch_taken;
        // A taken branch kills the dependent instruction, so no bubble.
        hazard   = (state == RUN) && load_use && !taken;
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        start     = 1'b0;
        stall_fe  = 1'b0;
        bubble_ex = 1'b0;
        stall_ex  = 1'b0;
        flush     = 1'b0;
        flushing  = 1'b0;
        stall_cnt = '0;
        flush_cnt = '0;
        if (!rst) begin
            stall_ex  = mem_busy;
            flush     = (state == FLUSH);
            flushing  = (state == FLUSH);
            stall_fe  = mem_busy || hazard;
            bubble_ex = hazard && !mem_busy;
            stall_cnt = stall_q;
            flush_cnt = flush_q;
            if (!mem_busy) begin
                unique case (state)
                    RUN: begin
                        if (taken) begin
                            state_nxt = FLUSH;
                            fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
                            start     = 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (fcnt == '0) state_nxt = RUN;
                        else fcnt_nxt = fcnt - FW'(1);
                    end
                    default: state_nxt = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            fcnt    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (stall_fe && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            if (start && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
        end
    end

endmodule
